// File: rtl/mem_io_responder_if.sv
// Data-memory bus between the core (initiator) and the memory/I-O responder.
interface mem_io_responder_if;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        mwr;
    logic        moe;
    logic [31:0] mrd;

    modport master (output ma, mwd, mwr, moe, input mrd);
    modport slave  (input ma, mwd, mwr, moe, output mrd);
endinterface

// File: rtl/mem_io_responder.sv
// Data-memory responder: word RAM plus memory-mapped switches, buttons, LED, hex display
// and button interrupts, with per-bit synchronize+debounce lanes for the raw board inputs.
module mem_io_db_bit #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          done;

    assign done = (sync[1] != db) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    // Accepted 0->1 edge, valid in the cycle before db flips
    assign rise = done & sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= '0;
            cnt  <= '0;
            db   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (done) begin
                db  <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module mem_io_responder #(
    parameter int          RAM_WORDS       = 1024,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter logic [31:0] IO_BASE         = 32'hFFFF_FF00
) (
    input  logic                      clock,
    input  logic                      reset,
    mem_io_responder_if.slave         bus,
    input  logic [15:0]               sw,
    input  logic [4:0]                btn,
    output logic [15:0]               led,
    output logic [31:0]               hex_data,
    output logic                      irq
);
    localparam int AW    = $clog2(RAM_WORDS);
    localparam int LANES = 21;

    logic [31:0]       ram [RAM_WORDS];
    logic [LANES-1:0]  raw_in, db_all, rise_all;
    logic [15:0]       sw_db;
    logic [4:0]        btn_db, btn_rise;
    logic [4:0]        pending, mask, pending_next, mask_next, pend_clr;
    logic              ram_hit, io_hit;
    logic [AW-1:0]     ram_idx;
    logic [29:0]       io_woff;
    logic [2:0]        io_reg;
    logic              sel_led, sel_hex, sel_pnd, sel_msk;
    logic [31:0]       rdata;
    logic [1:0]        unused_ma;

    assign raw_in = {btn, sw};

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mem_io_db_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clock (clock),
            .reset (reset),
            .raw   (raw_in[i]),
            .db    (db_all[i]),
            .rise  (rise_all[i])
        );
    end

    assign sw_db    = db_all[15:0];
    assign btn_db   = db_all[20:16];
    assign btn_rise = rise_all[20:16];

    // Word-granular decode; byte offset bits play no part
    assign unused_ma = bus.ma[1:0];
    assign ram_hit   = (bus.ma[31:AW+2] == '0);
    assign ram_idx   = bus.ma[AW+1:2];
    assign io_woff   = bus.ma[31:2] - IO_BASE[31:2];
    assign io_hit    = !ram_hit && (io_woff[29:3] == '0);
    assign io_reg    = io_woff[2:0];
    assign sel_led   = io_hit && (io_reg == 3'd2);
    assign sel_hex   = io_hit && (io_reg == 3'd3);
    assign sel_pnd   = io_hit && (io_reg == 3'd4);
    assign sel_msk   = io_hit && (io_reg == 3'd5);

    // A new edge and a W1C on the same bit leave the bit set
    assign pend_clr     = (bus.mwr && sel_pnd) ? bus.mwd[4:0] : 5'd0;
    assign pending_next = (pending & ~pend_clr) | btn_rise;
    assign mask_next    = (bus.mwr && sel_msk) ? bus.mwd[4:0] : mask;

    // RAM is not reset, so a write during reset still lands
    always_ff @(posedge clock) begin
        if (bus.mwr && ram_hit) ram[ram_idx] <= bus.mwd;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led      <= '0;
            hex_data <= '0;
            pending  <= '0;
            mask     <= '0;
            irq      <= 1'b0;
        end else begin
            if (bus.mwr && sel_led) led      <= bus.mwd[15:0];
            if (bus.mwr && sel_hex) hex_data <= bus.mwd;
            pending <= pending_next;
            mask    <= mask_next;
            irq     <= |(pending_next & mask_next);
        end
    end

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = ram[ram_idx];
        end else if (io_hit) begin
            case (io_reg)
                3'd0:    rdata = {16'b0, sw_db};
                3'd1:    rdata = {27'b0, btn_db};
                3'd2:    rdata = {16'b0, led};
                3'd3:    rdata = hex_data;
                3'd4:    rdata = {27'b0, pending};
                3'd5:    rdata = {27'b0, mask};
                default: rdata = '0;
            endcase
        end
    end

    assign bus.mrd = bus.moe ? rdata : 32'd0;
endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with short debounce and a 16-word RAM.
module tb_mem_io_responder;
    localparam logic [31:0] A_SW  = 32'hFFFF_FF00;
    localparam logic [31:0] A_BTN = 32'hFFFF_FF04;
    localparam logic [31:0] A_LED = 32'hFFFF_FF08;
    localparam logic [31:0] A_HEX = 32'hFFFF_FF0C;
    localparam logic [31:0] A_PND = 32'hFFFF_FF10;
    localparam logic [31:0] A_MSK = 32'hFFFF_FF14;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [15:0] led;
    logic [31:0] hex_data;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    mem_io_responder_if bus();

    mem_io_responder #(.RAM_WORDS(16), .DEBOUNCE_CYCLES(4), .IO_BASE(32'hFFFF_FF00)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .sw       (sw),
        .btn      (btn),
        .led      (led),
        .hex_data (hex_data),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.ma = a; bus.mwd = d; bus.mwr = 1'b1;
        tick();
        bus.mwr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.ma = a; bus.moe = 1'b1;
        #1;
        d = bus.mrd;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; sw = '0; btn = '0;
        bus.ma = '0; bus.mwd = '0; bus.mwr = 1'b0; bus.moe = 1'b0;
        tick(); tick();
        checks++; if ({led, hex_data, irq} !== 49'd0) begin errors++; $display("FAIL reset_outputs: got led=%h hex=%h irq=%b expected 0", led, hex_data, irq); end
        reset = 1'b0;
        bus_rd(A_PND, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h expected 0", d); end
        bus_rd(A_SW, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_sw: got %h expected 0", d); end
    endtask

    task automatic test_ram();
        logic [31:0] d;
        bus_wr(32'h3C, 32'hDEADBEEF);
        bus_wr(32'h00, 32'h77);
        bus_wr(32'h40, 32'h99);
        bus_rd(32'h3C, d);
        checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rw: got %h expected deadbeef", d); end
        bus_rd(32'h40, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ram_oob_read: got %h expected 0", d); end
        bus_rd(32'h00, d);
        checks++; if (d !== 32'h77) begin errors++; $display("FAIL ram_no_alias: got %h expected 77", d); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        bus_wr(32'h08, 32'h11);
        bus.ma = 32'h08; bus.mwd = 32'h22; bus.mwr = 1'b1; bus.moe = 1'b1;
        #1;
        checks++; if (bus.mrd !== 32'h11) begin errors++; $display("FAIL rw_same_old: got %h expected 11", bus.mrd); end
        tick();
        bus.mwr = 1'b0;
        bus_rd(32'h08, d);
        checks++; if (d !== 32'h22) begin errors++; $display("FAIL rw_same_new: got %h expected 22", d); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        sw[0] = 1'b1;
        tick(); tick(); tick();
        sw[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            bus_rd(A_SW, d);
            checks++; if (d !== 32'd0) begin errors++; $display("FAIL sw_glitch: cycle %0d got %h expected 0", k, d); end
        end
    endtask

    task automatic test_switch_debounce();
        logic [31:0] d;
        sw = 16'hA5A5;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus_rd(A_SW, d);
            checks++;
            if (d !== ((k < 6) ? 32'd0 : 32'h0000A5A5)) begin
                errors++; $display("FAIL sw_debounce: cycle %0d got %h expected %h", k, d, (k < 6) ? 32'd0 : 32'h0000A5A5);
            end
        end
    endtask

    task automatic test_led_hex();
        logic [31:0] d;
        bus_wr(A_LED, 32'hFFFF1234);
        checks++; if (led !== 16'h1234) begin errors++; $display("FAIL led_out: got %h expected 1234", led); end
        bus_rd(A_LED, d);
        checks++; if (d !== 32'h00001234) begin errors++; $display("FAIL led_read: got %h expected 00001234", d); end
        bus_wr(A_HEX, 32'h01234567);
        checks++; if (hex_data !== 32'h01234567) begin errors++; $display("FAIL hex_out: got %h expected 01234567", hex_data); end
        bus_wr(A_SW, 32'h0);
        bus_rd(A_SW, d);
        checks++; if (d !== 32'h0000A5A5) begin errors++; $display("FAIL sw_write_ignored: got %h expected 0000a5a5", d); end
    endtask

    task automatic test_moe();
        bus.ma = 32'h3C; bus.moe = 1'b0;
        #1;
        checks++; if (bus.mrd !== 32'd0) begin errors++; $display("FAIL moe_low: got %h expected 0", bus.mrd); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        bus_wr(A_MSK, 32'h01);
        bus_rd(A_MSK, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL mask_read: got %h expected 1", d); end
        btn[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus_rd(A_PND, d);
        checks++; if (d !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL irq_early: got pnd=%h irq=%b expected 0/0", d, irq); end
        tick();
        bus_rd(A_PND, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL btnd_pending: got %h expected 1", d); end
        bus_rd(A_BTN, d);
        checks++; if (d !== 32'h01) begin errors++; $display("FAIL btn_read: got %h expected 1", d); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL btnd_irq: got %b expected 1", irq); end
        bus_wr(A_PND, 32'h01);
        bus_rd(A_PND, d);
        checks++; if (d !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL w1c: got pnd=%h irq=%b expected 0/0", d, irq); end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        btn[1] = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        bus_rd(A_PND, d);
        checks++; if (d !== 32'h02) begin errors++; $display("FAIL btnr_pending: got %h expected 2", d); end
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL btnr_masked_irq: got %b expected 0", irq); end
    endtask

    task automatic test_set_vs_clear();
        logic [31:0] d;
        btn = '0;
        for (int k = 0; k < 8; k++) tick();
        btn[0] = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        bus.ma = A_PND; bus.mwd = 32'h01; bus.mwr = 1'b1;
        tick();
        bus.mwr = 1'b0;
        bus_rd(A_PND, d);
        checks++; if (d !== 32'h03) begin errors++; $display("FAIL set_beats_clear: got %h expected 3", d); end
        tick();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL set_beats_clear_irq: got %b expected 1", irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        btn[2] = 1'b1;
        tick(); tick(); tick();
        reset = 1'b1; btn = '0;
        bus.ma = 32'h04; bus.mwd = 32'h55; bus.mwr = 1'b1;
        tick();
        bus.mwr = 1'b0; reset = 1'b0;
        checks++; if ({led, hex_data, irq} !== 49'd0) begin errors++; $display("FAIL reset_mid_outputs: got led=%h hex=%h irq=%b expected 0", led, hex_data, irq); end
        bus_rd(32'h04, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL reset_ram_write: got %h expected 55", d); end
        for (int k = 0; k < 8; k++) tick();
        bus_rd(A_BTN, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_mid_db: got %h expected 0", d); end
        bus_rd(A_PND, d);
        checks++; if (d !== 32'd0 || irq !== 1'b0) begin errors++; $display("FAIL reset_mid_irq: got pnd=%h irq=%b expected 0/0", d, irq); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_same_cycle();
        test_glitch();
        test_switch_debounce();
        test_led_hex();
        test_moe();
        test_irq();
        test_masked();
        test_set_vs_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
